debounce: RTL and testbench

Counter-based debouncer for a single mechanical push-button or switch input on the board clock. It synchronizes the asynchronous pin and ignores any level that is not held stable for 2^width_p consecutive clocks. It drives a clean level plus single-cycle edge pulses to downstream control logic. One instance per button; a typical configuration is width_p=11 at 100 MHz, giving a 20.48 us stability window.

---
 rtl/debounce.sv | 81 ++++++++
 tb/tb_debounce.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/debounce.sv
// Counter-based push-button debouncer: ignores any level not held for 2^width_p clocks.
// Define DEBOUNCE_SYNC_EN to include the two-flop input synchronizer for raw asynchronous pins.
module debounce #(
    parameter int unsigned width_p     = 11,
    parameter bit          reset_val_p = 1'b0
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic button_i,
    output logic debounce_o,
    output logic rise_o,
    output logic fall_o
);

    logic               s;
    logic [width_p-1:0] cnt_q, cnt_d;
    logic               deb_q, deb_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;

`ifdef DEBOUNCE_SYNC_EN
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = button_i;
        s2_d = s1_q;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            s1_q <= reset_val_p;
            s2_q <= reset_val_p;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign s = s2_q;
`else
    // Input is already synchronous to clk_i.
    assign s = button_i;
`endif

    always_comb begin
        cnt_d  = '0;
        deb_d  = deb_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s != deb_q) begin
            if (cnt_q == '1) begin
                // Window complete: accept the new level and restart from zero.
                deb_d  = s;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + width_p'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q  <= '0;
            deb_q  <= reset_val_p;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign debounce_o = deb_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;

endmodule

// File: tb/tb_debounce.sv
// Self-checking bench for debounce: width_p=11 and width_p=4 instances share one stimulus,
// both compared every cycle against a sliding-window reference model.
module tb_debounce;

`ifdef DEBOUNCE_SYNC_EN
    localparam int Extra = 2;
`else
    localparam int Extra = 0;
`endif
    localparam int Lat11 = 2048 + Extra;
    localparam int Lat4  = 16 + Extra;

    logic clk = 1'b0;
    logic reset_n;
    logic button;
    logic deb11, rise11, fall11;
    logic deb4, rise4, fall4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debounce #(.width_p(11), .reset_val_p(1'b0)) u_dut11 (
        .clk_i(clk), .reset_i(reset_n), .button_i(button),
        .debounce_o(deb11), .rise_o(rise11), .fall_o(fall11)
    );

    debounce #(.width_p(4), .reset_val_p(1'b0)) u_dut4 (
        .clk_i(clk), .reset_i(reset_n), .button_i(button),
        .debounce_o(deb4), .rise_o(rise4), .fall_o(fall4)
    );

    // Reference: a level is accepted once the last N sampled values since reset all
    // differ from the current output. Sampled value is the pin delayed by the synchronizer.
    int unsigned nwin[2] = '{2048, 16};
    bit          p1[2];
    bit          p2[2];
    bit          hist[2][$];
    bit          m_deb[2];
    bit          m_rise[2];
    bit          m_fall[2];

    task automatic model_edge(input int i, input bit b, input bit r);
        bit s;
        bit flip;
        if (!r) begin
            p1[i] = 1'b0;
            p2[i] = 1'b0;
            hist[i].delete();
            m_deb[i]  = 1'b0;
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
        end else begin
`ifdef DEBOUNCE_SYNC_EN
            s     = p2[i];
            p2[i] = p1[i];
            p1[i] = b;
`else
            s = b;
`endif
            hist[i].push_back(s);
            if (hist[i].size() > nwin[i]) void'(hist[i].pop_front());
            flip = (hist[i].size() == nwin[i]);
            foreach (hist[i][k]) begin
                if (hist[i][k] == m_deb[i]) begin
                    flip = 1'b0;
                    break;
                end
            end
            m_rise[i] = flip && s;
            m_fall[i] = flip && !s;
            if (flip) m_deb[i] = s;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit b, input bit r);
        button  = b;
        reset_n = r;
        @(posedge clk);
        model_edge(0, b, r);
        model_edge(1, b, r);
        #1;
        chk("deb11", deb11, m_deb[0]);
        chk("rise11", rise11, m_rise[0]);
        chk("fall11", fall11, m_fall[0]);
        chk("deb4", deb4, m_deb[1]);
        chk("rise4", rise4, m_rise[1]);
        chk("fall4", fall4, m_fall[1]);
    endtask

    task automatic run(input bit b, input bit r, input int n);
        repeat (n) step(b, r);
    endtask

    initial begin
        int lat;
        int rises;
        bit lvl;
        button  = 1'b0;
        reset_n = 1'b0;
        #1;

        // Reset hold with the pin toggling.
        for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)), 1'b0);
        run(1'b0, 1'b1, 40);

        // Bounce rejection on the wide instance.
        run(1'b1, 1'b1, 40);
        run(1'b0, 1'b1, 80);
        run(1'b1, 1'b1, 80);
        run(1'b0, 1'b1, 80);
        chk("bounce_no_change", deb11, 1'b0);

        // Stable press held 40 us.
        lat   = -1;
        rises = 0;
        for (int k = 1; k <= 4000; k++) begin
            step(1'b1, 1'b1);
            if (rise11) rises++;
            if (lat < 0 && deb11) lat = k;
        end
        chk_int("press_latency", lat, Lat11);
        chk_int("press_rise_count", rises, 1);

        // Short release rejected.
        run(1'b0, 1'b1, 400);
        run(1'b1, 1'b1, 400);
        chk("short_release_held", deb11, 1'b1);

        // Release with glitches then held low.
        run(1'b0, 1'b1, 40);
        run(1'b1, 1'b1, 80);
        run(1'b0, 1'b1, 80);
        run(1'b1, 1'b1, 80);
        lat   = -1;
        rises = 0;
        for (int k = 1; k <= 4000; k++) begin
            step(1'b0, 1'b1);
            if (fall11) rises++;
            if (lat < 0 && !deb11) lat = k;
        end
        chk_int("release_latency", lat, Lat11);
        chk_int("release_fall_count", rises, 1);

        // Reset mid-count on the narrow instance.
        run(1'b1, 1'b1, 10);
        step(1'b1, 1'b0);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            step(1'b1, 1'b1);
            if (lat < 0 && deb4) lat = k;
        end
        chk_int("midcount_reset_latency", lat, Lat4);

        // Random runs of varying length, mostly around the narrow window.
        lvl = 1'b0;
        for (int i = 0; i < 200; i++) begin
            lvl = ~lvl;
            run(lvl, 1'b1, $urandom_range(1, 30));
            if ($urandom_range(0, 40) == 0) step(lvl, 1'b0);
        end
        run(1'b0, 1'b1, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
